uart_frame_loader: RTL

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

---
 rtl/uart_frame_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_frame_loader.sv
// Assembles UART byte pairs into 16-bit pixel writes after an A5 5A header; write lands 1 cycle after the high byte.
// No backpressure: every rx_valid byte is consumed; idle gaps mid-frame beyond TIMEOUT_CYC force a header resync.
module uart_frame_loader #(
  parameter int FRAME_WORDS = 4096,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic        clk920k,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        continuous,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [15:0] data_counter,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, LO, HI} state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] idle_q, idle_d;

  always_ff @(posedge clk920k or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      lo_q      <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      lo_q      <= lo_d;
      idle_q    <= idle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    tmo_d     = tmo_q;
    lo_d      = lo_q;
    idle_d    = idle_q;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      idle_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          idle_d = '0;
          if (start) begin
            state_d = HDR0;
            cnt_d   = '0;
            tmo_d   = 1'b0;
          end
        end
        HDR0: begin
          idle_d = '0;
          if (rx_valid && rx_data == 8'hA5) state_d = HDR1;
        end
        default: begin
          // A byte arriving on the would-be timeout cycle wins over the timeout.
          if (rx_valid) begin
            idle_d = '0;
            case (state_q)
              HDR1: begin
                if (rx_data == 8'h5A)      state_d = LO;
                else if (rx_data != 8'hA5) state_d = HDR0;
              end
              LO: begin
                lo_d    = rx_data;
                state_d = HI;
              end
              HI: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = {rx_data, lo_q};
                cnt_d     = cnt_q + 16'd1;
                state_d   = LO;
                if (cnt_q == LAST_IDX) begin
                  done_d = 1'b1;
                  if (continuous) begin
                    state_d = HDR0;
                    cnt_d   = '0;
                  end else begin
                    state_d = IDLE;
                  end
                end
              end
              default: state_d = state_q;
            endcase
          end else if (idle_q >= TMO_LAST) begin
            state_d = HDR0;
            tmo_d   = 1'b1;
            cnt_d   = '0;
            lo_d    = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 16'd1;
          end
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign data_counter = cnt_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign timeout_err  = tmo_q;

endmodule
